// File: rtl/mul_test_pkg.sv
// Shared definitions for the multiplier stimulus checker: FSM encoding,
// LFSR feedback mask, and the fixed corner vectors issued before LFSR vectors.
package mul_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int unsigned NUM_CORNERS = 4;

  localparam logic [31:0] CORNER_A [0:3] = '{32'h0000_0000, 32'hFFFF_FFFF,
                                              32'h0000_0001, 32'h8000_0000};
  localparam logic [31:0] CORNER_B [0:3] = '{32'h0000_0000, 32'hFFFF_FFFF,
                                              32'hFFFF_FFFF, 32'h0000_0002};

  // Right-shifting Galois step: feedback applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/mul_stim_checker_if.sv
// Operand/result bus between the stimulus checker and the multiplier under test.
interface mul_stim_checker_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] x;

  modport master (input start, input x, output a, output b);
  modport slave  (output start, output x, input a, input b);
endinterface

// File: rtl/mul_lfsr32.sv
// 32-bit Galois LFSR with synchronous reseed; an all-zero seed is replaced by 1
// so the register can never lock up.
module mul_lfsr32
  import mul_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] seed_d;

  always_comb begin
    seed_d = (seed == '0) ? 32'h0000_0001 : seed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 32'h0000_0001;
    end else if (load) begin
      q_q <= seed_d;
    end else if (step) begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mul_stim_checker.sv
// Self-checking stimulus engine: drives a/b into the multiplier, computes the
// golden product with a 32-cycle shift-add model, and compares x at CHECK.
module mul_stim_checker
  import mul_test_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] SEED_A      = 32'h1234_5678,
  parameter logic [31:0] SEED_B      = 32'h9ABC_DEF1
) (
  input  logic                      clk,
  input  logic                      rst,
  mul_stim_checker_if.master        bus,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               vec_count,
  output logic [15:0]               err_count,
  output logic [31:0]               first_err_a,
  output logic [31:0]               first_err_b,
  output logic [31:0]               first_err_x
);

  // The 32-cycle RUN window covers any multiplier latency up to 31 cycles.
  if (LATENCY > 31 || NUM_VECTORS < 4 || NUM_VECTORS > 65535) begin : g_param_check
    $error("mul_stim_checker: parameter out of legal range");
  end

  state_e      state_q;
  logic [4:0]  cyc_q;
  logic [15:0] vidx_q;
  logic [31:0] a_q, b_q;
  logic [31:0] acc_q, mcand_q, mplier_q;
  logic [15:0] vec_count_q, err_count_q;
  logic [31:0] fea_q, feb_q, fex_q;
  logic        busy_q, done_q, pass_q;

  logic        start_ok_d, last_d, mismatch_d, step_d;
  logic [15:0] nidx_d, err_next_d;
  logic [31:0] next_a_d, next_b_d;
  logic [31:0] lfsr_a, lfsr_b;

  always_comb begin
    start_ok_d = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    nidx_d     = vidx_q + 16'd1;
    last_d     = (nidx_d == 16'(NUM_VECTORS));
    mismatch_d = (bus.x != acc_q);
    err_next_d = err_count_q;
    if (mismatch_d && (err_count_q != 16'hFFFF)) begin
      err_next_d = err_count_q + 16'd1;
    end
    if (nidx_d < 16'(NUM_CORNERS)) begin
      next_a_d = CORNER_A[nidx_d[1:0]];
      next_b_d = CORNER_B[nidx_d[1:0]];
    end else begin
      next_a_d = lfsr_a;
      next_b_d = lfsr_b;
    end
    // Advance only when an LFSR state is consumed as the next vector.
    step_d = (state_q == ST_CHECK) && !last_d && (nidx_d >= 16'(NUM_CORNERS));
  end

  mul_lfsr32 u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok_d),
    .seed (SEED_A),
    .step (step_d),
    .q    (lfsr_a)
  );

  mul_lfsr32 u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok_d),
    .seed (SEED_B),
    .step (step_d),
    .q    (lfsr_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      vidx_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      fea_q       <= '0;
      feb_q       <= '0;
      fex_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q     <= ST_RUN;
            cyc_q       <= '0;
            vidx_q      <= '0;
            a_q         <= CORNER_A[0];
            b_q         <= CORNER_B[0];
            acc_q       <= '0;
            mcand_q     <= CORNER_A[0];
            mplier_q    <= CORNER_B[0];
            vec_count_q <= '0;
            err_count_q <= '0;
            fea_q       <= '0;
            feb_q       <= '0;
            fex_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cyc_q    <= cyc_q + 5'd1;
          if (cyc_q == 5'd31) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          vec_count_q <= vec_count_q + 16'd1;
          err_count_q <= err_next_d;
          if (mismatch_d && (err_count_q == '0)) begin
            fea_q <= a_q;
            feb_q <= b_q;
            fex_q <= bus.x;
          end
          if (last_d) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_next_d == '0);
          end else begin
            state_q  <= ST_RUN;
            cyc_q    <= '0;
            vidx_q   <= nidx_d;
            a_q      <= next_a_d;
            b_q      <= next_b_d;
            acc_q    <= '0;
            mcand_q  <= next_a_d;
            mplier_q <= next_b_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.a       = a_q;
  assign bus.b       = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign vec_count   = vec_count_q;
  assign err_count   = err_count_q;
  assign first_err_a = fea_q;
  assign first_err_b = feb_q;
  assign first_err_x = fex_q;

endmodule
